// File: rtl/image_pipe_arb.sv
// Two-source frame arbiter feeding one registered image-pipe stream.
// Grants are frame-atomic; ties in IDLE alternate round robin.
module image_pipe_arb #(
    parameter int DW = 32,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s0_data_in,
    input  logic          s0_valid_in,
    input  logic          s0_end_in,
    output logic          s0_busy_out,
    input  logic [DW-1:0] s1_data_in,
    input  logic          s1_valid_in,
    input  logic          s1_end_in,
    output logic          s1_busy_out,
    output logic [DW-1:0] m_data_out,
    output logic          m_valid_out,
    output logic          m_end_out,
    input  logic          m_busy_in,
    output logic [1:0]    grant_out,
    output logic          frame_done_out,
    output logic [LW-1:0] frame_len_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    localparam logic [LW-1:0] CountMax = {LW{1'b1}};

    state_e        state_q, state_d;
    logic          last_src_q, last_src_d;
    logic [LW-1:0] count_q, count_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_end_q, m_end_d;
    logic          frame_done_q, frame_done_d;
    logic [LW-1:0] frame_len_q, frame_len_d;

    logic [DW-1:0] sel_data;
    logic          sel_valid;
    logic          sel_end;
    logic          accept;
    logic [LW-1:0] count_inc;

    // The granted source sees downstream backpressure directly; everyone else stalls.
    assign s0_busy_out    = (state_q == GNT0 && !rst) ? m_busy_in : 1'b1;
    assign s1_busy_out    = (state_q == GNT1 && !rst) ? m_busy_in : 1'b1;
    assign grant_out      = rst ? 2'b00 : {state_q == GNT1, state_q == GNT0};
    assign m_data_out     = m_data_q;
    assign m_valid_out    = m_valid_q;
    assign m_end_out      = m_end_q;
    assign frame_done_out = frame_done_q;
    assign frame_len_out  = frame_len_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d      = state_q;
        last_src_d   = last_src_q;
        count_d      = count_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_end_d      = m_end_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;

        sel_data  = (state_q == GNT1) ? s1_data_in : s0_data_in;
        sel_valid = (state_q == GNT0) ? s0_valid_in :
                    (state_q == GNT1) ? s1_valid_in : 1'b0;
        sel_end   = (state_q == GNT0) ? s0_end_in :
                    (state_q == GNT1) ? s1_end_in : 1'b0;
        accept    = sel_valid && !m_busy_in;
        count_inc = (count_q == CountMax) ? count_q : count_q + 1'b1;

        if (!m_busy_in) begin
            m_data_d  = sel_data;
            m_valid_d = accept;
            m_end_d   = accept && sel_end;
        end

        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (s0_valid_in && s1_valid_in) begin
                    state_d = last_src_q ? GNT0 : GNT1;
                end else if (s0_valid_in) begin
                    state_d = GNT0;
                end else if (s1_valid_in) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (accept) begin
                    count_d = count_inc;
                    if (sel_end) begin
                        state_d      = IDLE;
                        last_src_d   = (state_q == GNT1);
                        frame_done_d = 1'b1;
                        frame_len_d  = count_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the output data register is reset too, so the stream reads zero out of reset.
            state_q      <= IDLE;
            last_src_q   <= 1'b1;
            count_q      <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_end_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_src_q   <= last_src_d;
            count_q      <= count_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_end_q      <= m_end_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
        end
    end

endmodule

// File: tb/tb_image_pipe_arb.sv
// Bench for image_pipe_arb: directed frame scenarios plus random traffic,
// scored against a frame-level arbitration model; a second LW=4 instance checks saturation.
module tb_image_pipe_arb;

    localparam int DW = 32;
    localparam int LW = 16;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s0_data, s1_data;
    logic          s0_valid, s1_valid, s0_end, s1_end;
    logic          m_busy;

    logic          s0_busy, s1_busy, m_valid, m_end, frame_done;
    logic [DW-1:0] m_data;
    logic [1:0]    grant;
    logic [LW-1:0] frame_len;

    logic          b_s0_busy, b_s1_busy, b_m_valid, b_m_end, b_frame_done;
    logic [DW-1:0] b_m_data;
    logic [1:0]    b_grant;
    logic [3:0]    b_frame_len;

    always #5 clk = ~clk;

    image_pipe_arb #(.DW(DW), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .s0_data_in(s0_data), .s0_valid_in(s0_valid), .s0_end_in(s0_end), .s0_busy_out(s0_busy),
        .s1_data_in(s1_data), .s1_valid_in(s1_valid), .s1_end_in(s1_end), .s1_busy_out(s1_busy),
        .m_data_out(m_data), .m_valid_out(m_valid), .m_end_out(m_end), .m_busy_in(m_busy),
        .grant_out(grant), .frame_done_out(frame_done), .frame_len_out(frame_len)
    );

    image_pipe_arb #(.DW(DW), .LW(4)) dut_lw4 (
        .clk(clk), .rst(rst),
        .s0_data_in(s0_data), .s0_valid_in(s0_valid), .s0_end_in(s0_end), .s0_busy_out(b_s0_busy),
        .s1_data_in(s1_data), .s1_valid_in(s1_valid), .s1_end_in(s1_end), .s1_busy_out(b_s1_busy),
        .m_data_out(b_m_data), .m_valid_out(b_m_valid), .m_end_out(b_m_end), .m_busy_in(m_busy),
        .grant_out(b_grant), .frame_done_out(b_frame_done), .frame_len_out(b_frame_len)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Source word queues and the reference model state.
    word_t q0[$];
    word_t q1[$];
    int owner = -1;          // -1 idle, else index of the source holding the frame
    int last_owner = 1;
    int cnt = 0;
    int cnt4 = 0;
    logic [DW-1:0] e_data = '0;
    bit e_valid = 0, e_end = 0, e_done = 0;
    int e_len = 0, e_len4 = 0;
    int acc_words = 0, seen_words = 0, done_pulses = 0;
    logic [DW-1:0] out_log[$];

    task automatic push_frame(input int src, input int len, input logic [DW-1:0] base);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.data = base + DW'(i);
            w.last = (i == len - 1);
            if (src == 0) q0.push_back(w);
            else          q1.push_back(w);
        end
    endtask

    task automatic cycle(input bit r, input bit w0, input bit w1, input bit mb);
        bit v[2];
        bit en[2];
        logic [DW-1:0] d[2];
        bit acc;
        bit pop0, pop1;
        int exp_grant;

        @(negedge clk);
        rst      = r;
        m_busy   = mb;
        s0_valid = w0 && (q0.size() > 0);
        s1_valid = w1 && (q1.size() > 0);
        s0_data  = (q0.size() > 0) ? q0[0].data : $urandom;
        s1_data  = (q1.size() > 0) ? q1[0].data : $urandom;
        s0_end   = (q0.size() > 0) ? q0[0].last : 1'b0;
        s1_end   = (q1.size() > 0) ? q1[0].last : 1'b0;
        v[0] = s0_valid; v[1] = s1_valid;
        en[0] = s0_end;  en[1] = s1_end;
        d[0] = s0_data;  d[1] = s1_data;
        #1;

        exp_grant = (r || owner < 0) ? 0 : (1 << owner);
        check("grant", grant, exp_grant);
        check("s0_busy", s0_busy, (!r && owner == 0) ? mb : 1'b1);
        check("s1_busy", s1_busy, (!r && owner == 1) ? mb : 1'b1);

        pop0 = 0;
        pop1 = 0;
        if (r) begin
            owner = -1; last_owner = 1; cnt = 0; cnt4 = 0;
            e_data = '0; e_valid = 0; e_end = 0; e_done = 0; e_len = 0; e_len4 = 0;
        end else begin
            acc    = (owner >= 0) && v[owner] && !mb;
            e_done = acc && en[owner];
            if (!mb) begin
                e_valid = acc;
                e_end   = acc && en[owner];
                if (acc) e_data = d[owner];
            end
            if (acc) begin
                acc_words++;
                if (owner == 0) pop0 = 1; else pop1 = 1;
                cnt  = (cnt  < 65535) ? cnt + 1  : cnt;
                cnt4 = (cnt4 < 15)    ? cnt4 + 1 : cnt4;
                if (en[owner]) begin
                    e_len = cnt; e_len4 = cnt4; last_owner = owner; owner = -1;
                end
            end else if (owner < 0) begin
                if (v[0] && v[1]) owner = 1 - last_owner;
                else if (v[0])    owner = 0;
                else if (v[1])    owner = 1;
                cnt = 0; cnt4 = 0;
            end
        end

        @(posedge clk);
        #1;
        check("m_valid", m_valid, e_valid);
        check("m_end", m_end, e_end);
        check("frame_done", frame_done, e_done);
        check("frame_len", frame_len, e_len);
        check("frame_len_lw4", b_frame_len, e_len4);
        check("m_valid_lw4", b_m_valid, e_valid);
        if (e_valid) check("m_data", m_data, e_data);
        if (!r && !mb && m_valid) begin
            seen_words++;
            out_log.push_back(m_data);
        end
        if (frame_done) done_pulses++;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
    endtask

    initial begin
        rst = 1'b1; m_busy = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0; s0_end = 1'b0; s1_end = 1'b0;
        s0_data = '0; s1_data = '0;

        // Reset state, with downstream stalled to show reset overrides it.
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 0);
        check("reset_m_data", m_data, 0);

        // Simultaneous 3-word frames: s0 first, then s1.
        out_log.delete();
        push_frame(0, 3, 32'hA0);
        push_frame(1, 3, 32'hB0);
        for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0);
        check("tie_words", out_log.size(), 6);
        if (out_log.size() == 6) begin
            check("tie_w0", out_log[0], 32'hA0);
            check("tie_w2", out_log[2], 32'hA2);
            check("tie_w3", out_log[3], 32'hB0);
            check("tie_w5", out_log[5], 32'hB2);
        end
        check("tie_len", frame_len, 3);

        // Downstream stall for 4 cycles mid-frame.
        out_log.delete();
        push_frame(0, 6, 32'hC0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);
        check("stall_words", out_log.size(), 6);
        if (out_log.size() == 6) check("stall_w3", out_log[3], 32'hC3);

        // Three single-word frames from s1 only.
        out_log.delete();
        done_pulses = 0;
        for (int i = 0; i < 3; i++) push_frame(1, 1, 32'hD0 + DW'(i));
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0);
        check("one_word_done", done_pulses, 3);
        check("one_word_len", frame_len, 1);

        // s0 valid gap while s1 is requesting.
        out_log.delete();
        push_frame(0, 4, 32'hE0);
        push_frame(1, 2, 32'hF0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
        check("gap_grant", grant, 2'b01);
        for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0);
        if (out_log.size() == 6) check("gap_order", out_log[4], 32'hF0);
        else check("gap_words", out_log.size(), 6);

        // Reset on the second word of a frame, then fresh arbitration.
        push_frame(0, 4, 32'h100);
        push_frame(1, 4, 32'h200);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        cycle(1, 1, 1, 0);
        q0.delete();
        q1.delete();
        check("rst_mid_valid", m_valid, 0);
        out_log.delete();
        push_frame(1, 2, 32'h280);
        push_frame(0, 2, 32'h180);
        for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0);
        if (out_log.size() > 0) check("rst_s0_first", out_log[0], 32'h180);
        else check("rst_words", out_log.size(), 4);

        // 20-word frame: LW=4 instance saturates at 15.
        out_log.delete();
        push_frame(1, 20, 32'h300);
        for (int i = 0; i < 26; i++) cycle(0, 0, 1, 0);
        check("sat_words", out_log.size(), 20);
        check("sat_len4", b_frame_len, 15);
        check("sat_len16", frame_len, 20);
        if (out_log.size() == 20) check("sat_last", out_log[19], 32'h313);

        // Random traffic with random backpressure.
        for (int f = 0; f < 20; f++) begin
            push_frame(0, $urandom_range(1, 20), {8'h10, 8'(f), 16'h0});
            push_frame(1, $urandom_range(1, 20), {8'h20, 8'(f), 16'h0});
        end
        for (int c = 0; c < 6000 && (q0.size() > 0 || q1.size() > 0 || owner >= 0); c++) begin
            cycle(0, ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) == 0);
        end
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        check("word_conservation", seen_words, acc_words);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
